// File: rtl/pc_ctrl_pkg.sv
// Shared fetch-control definitions: redirect FSM states, branch opcodes and
// the default sequential PC step.
package pc_ctrl_pkg;

   typedef enum logic {RUN, FLUSH} state_t;

   // Also decoded by the condition logic and the instruction decoder
   localparam logic [3:0] OP_B    = 4'b1000;
   localparam logic [3:0] OP_BCND = 4'b1001;

   localparam int DEF_PC_INC = 4;

endpackage

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: redirects on a taken execute-stage branch, squashes the
// wrong path and keeps a saturating count of taken redirects.
module pc_redirect_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter int                     PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0]    RESET_PC     = '0,
   parameter int                     PC_INC       = DEF_PC_INC,
   parameter int                     FLUSH_CYCLES = 1,
   parameter int                     CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 PCSrc,
   input  logic [PC_WIDTH-1:0]  branchTarget,
   output logic [PC_WIDTH-1:0]  pcF,
   output logic [PC_WIDTH-1:0]  pcPlusIncF,
   output logic                 flushD,
   output logic                 flushE,
   output logic                 redirectBusy,
   output logic [CNT_WIDTH-1:0] branchCount
);

   localparam logic [PC_WIDTH-1:0] W_INC      = PC_WIDTH'(PC_INC);
   localparam logic [2:0]          FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   state_t               r_state;
   logic [PC_WIDTH-1:0]  r_pc;
   logic [2:0]           r_flush_cnt;
   logic [CNT_WIDTH-1:0] r_branch_cnt;
   logic [PC_WIDTH-1:0]  w_pc_inc;
   logic                 w_redirect;

   assign w_pc_inc   = r_pc + W_INC;
   assign w_redirect = (r_state == RUN) && PCSrc;

   // Redirect beats stall: the wrong-path fetch must never be held.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc         <= RESET_PC;
         r_state      <= RUN;
         r_flush_cnt  <= '0;
         r_branch_cnt <= '0;
      end else begin
         case (r_state)
            RUN: begin
               if (PCSrc) begin
                  r_pc        <= branchTarget;
                  r_state     <= FLUSH;
                  r_flush_cnt <= FLUSH_INIT;
                  if (r_branch_cnt != '1)
                     r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
               end else if (!stall) begin
                  r_pc <= w_pc_inc;
               end
            end
            FLUSH: begin
               // The execute slot is a bubble here, so PCSrc cannot be real.
               if (!stall) begin
                  r_pc <= w_pc_inc;
                  if (r_flush_cnt == 3'd0) r_state <= RUN;
                  else                     r_flush_cnt <= r_flush_cnt - 3'd1;
               end
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign pcF          = r_pc;
   assign pcPlusIncF   = w_pc_inc;
   assign flushD       = reset || w_redirect || (r_state == FLUSH);
   assign flushE       = reset || w_redirect;
   assign redirectBusy = !reset && (r_state == FLUSH);
   assign branchCount  = r_branch_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: a default instance plus one with a
// 3-cycle flush window and a 2-bit counter.
module tb_pc_redirect_ctrl;

   logic        clk = 1'b0;
   int          checks = 0;
   int          errors = 0;

   logic        rst0, stall0, src0;
   logic [31:0] tgt0, pc0, pci0;
   logic        fd0, fe0, busy0;
   logic [15:0] cnt0;

   logic        rst1, stall1, src1;
   logic [31:0] tgt1, pc1, pci1;
   logic        fd1, fe1, busy1;
   logic [1:0]  cnt1;

   always #5 clk = ~clk;

   pc_redirect_ctrl dut0 (
      .clk(clk), .reset(rst0), .stall(stall0), .PCSrc(src0), .branchTarget(tgt0),
      .pcF(pc0), .pcPlusIncF(pci0), .flushD(fd0), .flushE(fe0),
      .redirectBusy(busy0), .branchCount(cnt0)
   );

   pc_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_WIDTH(2)) dut1 (
      .clk(clk), .reset(rst1), .stall(stall1), .PCSrc(src1), .branchTarget(tgt1),
      .pcF(pc1), .pcPlusIncF(pci1), .flushD(fd1), .flushE(fe1),
      .redirectBusy(busy1), .branchCount(cnt1)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst0 = 1; stall0 = 0; src0 = 0; tgt0 = '0;
      rst1 = 1; stall1 = 0; src1 = 0; tgt1 = '0;
      tick(); tick();
      checks++; if (pc0 !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc0, 32'h0); end
      checks++; if ({fd0, fe0, busy0} !== 3'b110) begin errors++; $display("FAIL reset_flush got %b exp 110", {fd0, fe0, busy0}); end
      checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt0); end
      rst0 = 0; rst1 = 0;
      #1;
      checks++; if ({fd0, fe0, busy0} !== 3'b000) begin errors++; $display("FAIL run_flush got %b exp 000", {fd0, fe0, busy0}); end
      checks++; if (pci0 !== 32'h4) begin errors++; $display("FAIL pcplus got %h exp %h", pci0, 32'h4); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++; if (pc0 !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d got %h exp %h", i, pc0, 32'(4 * i)); end
      end
      checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL seq_cnt got %0d exp 0", cnt0); end
   endtask

   task automatic test_redirect;
      tick();
      checks++; if (pc0 !== 32'h10) begin errors++; $display("FAIL pre_redirect_pc got %h exp 10", pc0); end
      src0 = 1; tgt0 = 32'h80;
      #1;
      checks++; if ({fd0, fe0} !== 2'b11) begin errors++; $display("FAIL redirect_flush got %b exp 11", {fd0, fe0}); end
      tick(); src0 = 0; #1;
      checks++; if (pc0 !== 32'h80) begin errors++; $display("FAIL redirect_pc got %h exp 80", pc0); end
      checks++; if ({fd0, fe0, busy0} !== 3'b101) begin errors++; $display("FAIL flush_state got %b exp 101", {fd0, fe0, busy0}); end
      tick();
      checks++; if (pc0 !== 32'h84) begin errors++; $display("FAIL post_flush_pc got %h exp 84", pc0); end
      checks++; if ({fd0, busy0} !== 2'b00) begin errors++; $display("FAIL post_flush got %b exp 00", {fd0, busy0}); end
      checks++; if (cnt0 !== 16'd1) begin errors++; $display("FAIL redirect_cnt got %0d exp 1", cnt0); end
   endtask

   task automatic test_redirect_over_stall;
      src0 = 1; stall0 = 1; tgt0 = 32'h40;
      tick(); src0 = 0; stall0 = 0; #1;
      checks++; if (pc0 !== 32'h40) begin errors++; $display("FAIL stall_redirect_pc got %h exp 40", pc0); end
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL stall_redirect_busy got %b exp 1", busy0); end
      tick();
      checks++; if (pc0 !== 32'h44 || busy0 !== 1'b0) begin errors++; $display("FAIL stall_redirect_exit got pc %h busy %b exp 44 0", pc0, busy0); end
      stall0 = 1;
      tick(); tick();
      checks++; if (pc0 !== 32'h44) begin errors++; $display("FAIL run_stall_hold got %h exp 44", pc0); end
      checks++; if ({fd0, fe0} !== 2'b00) begin errors++; $display("FAIL run_stall_flush got %b exp 00", {fd0, fe0}); end
      stall0 = 0;
      checks++; if (cnt0 !== 16'd2) begin errors++; $display("FAIL stall_cnt got %0d exp 2", cnt0); end
   endtask

   task automatic test_flush_ignores_pcsrc;
      src0 = 1; tgt0 = 32'h300;
      tick();
      tgt0 = 32'h200; #1;
      checks++; if (pc0 !== 32'h300) begin errors++; $display("FAIL ign_entry_pc got %h exp 300", pc0); end
      checks++; if ({fd0, fe0} !== 2'b10) begin errors++; $display("FAIL ign_flush got %b exp 10", {fd0, fe0}); end
      tick(); src0 = 0; #1;
      checks++; if (pc0 !== 32'h304) begin errors++; $display("FAIL ign_pc got %h exp 304", pc0); end
      checks++; if (cnt0 !== 16'd3) begin errors++; $display("FAIL ign_cnt got %0d exp 3", cnt0); end
      tick();
      checks++; if (pc0 !== 32'h308) begin errors++; $display("FAIL ign_seq_pc got %h exp 308", pc0); end
   endtask

   task automatic test_long_flush;
      logic [31:0] exp_pc [4];
      logic        exp_st [4];
      exp_pc = '{32'h100, 32'h104, 32'h104, 32'h108};
      exp_st = '{1'b0, 1'b1, 1'b0, 1'b0};
      src1 = 1; tgt1 = 32'h100;
      tick(); src1 = 0;
      for (int i = 0; i < 4; i++) begin
         stall1 = exp_st[i];
         #1;
         checks++; if (pc1 !== exp_pc[i] || busy1 !== 1'b1 || fd1 !== 1'b1) begin
            errors++; $display("FAIL long_flush%0d got pc %h busy %b fd %b exp %h 1 1", i, pc1, busy1, fd1, exp_pc[i]);
         end
         tick();
      end
      stall1 = 0; #1;
      checks++; if (pc1 !== 32'h10C || busy1 !== 1'b0 || fd1 !== 1'b0) begin
         errors++; $display("FAIL long_flush_exit got pc %h busy %b fd %b exp 10c 0 0", pc1, busy1, fd1);
      end
   endtask

   task automatic test_saturate_and_reset;
      for (int k = 0; k < 5; k++) begin
         src1 = 1; tgt1 = 32'h400 + 32'(k * 16);
         tick(); src1 = 0;
         tick(); tick(); tick();
         checks++; if (cnt1 !== ((k + 2 > 3) ? 2'd3 : 2'(k + 2))) begin
            errors++; $display("FAIL sat_cnt%0d got %0d exp %0d", k, cnt1, (k + 2 > 3) ? 3 : k + 2);
         end
      end
      checks++; if (pc1 !== 32'h44C || busy1 !== 1'b0) begin errors++; $display("FAIL sat_pc got %h busy %b exp 44c 0", pc1, busy1); end
      src1 = 1; tgt1 = 32'h500;
      tick(); src1 = 0; tick();
      rst1 = 1;
      tick();
      checks++; if (pc1 !== 32'h0 || cnt1 !== 2'd0 || busy1 !== 1'b0) begin
         errors++; $display("FAIL midflush_reset got pc %h cnt %0d busy %b exp 0 0 0", pc1, cnt1, busy1);
      end
      rst1 = 0;
      tick();
      checks++; if (pc1 !== 32'h4 || busy1 !== 1'b0 || fd1 !== 1'b0) begin
         errors++; $display("FAIL post_reset_run got pc %h busy %b fd %b exp 4 0 0", pc1, busy1, fd1);
      end
   endtask

   initial begin
      test_reset();
      test_redirect();
      test_redirect_over_stall();
      test_flush_ignores_pcsrc();
      test_long_flush();
      test_saturate_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
